// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive definitions: FSM state encodings, oversampling factor and tick divisor helper.
// Combinational constants only; no latency or backpressure of its own.
package uart_rx_fifo_pkg;

  localparam int BYTE_W     = 8;
  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Integer floor of clk/(16*baud), clamped so slow clocks still tick every cycle.
  function automatic int calc_div(input int freq, input int baud);
    int d;
    d = freq / (OVERSAMPLE * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead FIFO: head visible the cycle after push; pop when valid & ready.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int width = BYTE_W,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     ready,
  output logic [width-1:0]         head,
  output logic                     valid,
  output logic [$clog2(depth):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop;
  logic             full;
  logic             accept;

  assign count   = wr_ptr - rd_ptr;
  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(depth));
  assign pop     = valid & ready;
  // A same-cycle pop frees the slot the write lands in, so full+pop still accepts.
  assign accept  = push & (~full | pop);
  assign dropped = push & full & ~pop;
  assign head    = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampled, mid-bit sampling) feeding a show-ahead byte FIFO.
// Byte appears on rx_data one cycle after its stop-bit sample; full FIFO drops new bytes with an overrun pulse.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int clk_freq   = 100000000,
  parameter int baud_rate  = 1152000,
  parameter int fifo_depth = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int DIV = calc_div(clk_freq, baud_rate);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          rxd_meta;
  logic          rxd_s;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          start_det;
  logic [3:0]    scnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          stop_sample;
  logic          push;
  logic          stop_bad;
  logic          dropped;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Restarting the divider on the start edge aligns every later sample to mid-bit.
  assign start_det = (state == ST_IDLE) && !rxd_s;
  assign tick      = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || start_det) tick_cnt <= '0;
    else if (tick)        tick_cnt <= '0;
    else                  tick_cnt <= tick_cnt + 1'b1;
  end

  assign stop_sample = (state == ST_STOP) && tick && (scnt == 4'd15);
  assign push        = stop_sample && rxd_s;
  assign stop_bad    = stop_sample && !rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      scnt      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= dropped;
      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state <= ST_START;
            scnt  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (scnt == 4'd7) begin
              scnt    <= '0;
              bit_idx <= '0;
              state   <= rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (scnt == 4'd15) begin
              scnt    <= '0;
              shreg   <= {rxd_s, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= ST_STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (scnt == 4'd15) begin
              scnt  <= '0;
              state <= rxd_s ? ST_IDLE : ST_BREAK;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          // Held-low line must return high before another start bit is accepted.
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .width (8),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .ready     (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .count     (fifo_count),
    .dropped   (dropped)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven on rxd, received bytes checked against a queue.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_fifo #(
    .clk_freq   (100000000),
    .baud_rate  (1152000),
    .fifo_depth (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One bit = 80 clocks at DIV=5; frame starts one clock after the next rising edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] bv;
    bv = b;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (80) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = bv[i];
      repeat (80) @(posedge clk);
    end
    #1 rxd = stop_bit;
    repeat (80) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    @(posedge clk); #1 rx_ready = 1'b1;
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(tag, exp_q.size(), 0);
    check({tag, "_count"}, fifo_count, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (frame_err || overrun) check("err_exclusive", frame_err & overrun, 0);
      if (rx_valid && rx_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("rx_data", rx_data, exp_b);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_count", fifo_count, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Two clean bytes with the consumer always ready
    rx_ready = 1'b1;
    exp_q.push_back(8'h55); send_byte(8'h55, 1'b1);
    exp_q.push_back(8'hA3); send_byte(8'hA3, 1'b1);
    drain("t1_drain");
    check("t1_ferr", fe_cnt, 0);
    check("t1_ovr", ov_cnt, 0);

    // 30 ns glitch must be rejected at the start-bit re-sample
    @(posedge clk); #1 rxd = 1'b0;
    #30 rxd = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_valid", rx_valid, 0);

    // Framing error then a good byte
    send_byte(8'h0F, 1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_count", fifo_count, 0);
    exp_q.push_back(8'h3C); send_byte(8'h3C, 1'b1);
    drain("ferr_next");
    check("ferr_pulses_after", fe_cnt, 1);

    // Fill with nine bytes, ninth overruns
    @(posedge clk); #1 rx_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    @(negedge clk);
    check("full_count", fifo_count, 8);
    check("full_ovr", ov_cnt, 1);
    check("full_head", rx_data, 8'h01);

    // Pop exactly on the stop-bit push cycle of byte 0x0A (start + 763 clocks)
    exp_q.push_back(8'h0A);
    fork
      send_byte(8'h0A, 1'b1);
      begin
        @(posedge clk);
        repeat (762) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("poppush_count", fifo_count, 8);
    check("poppush_ovr", ov_cnt, 1);
    drain("full_drain");

    // Reset in the middle of bit 4, with a byte already buffered
    @(posedge clk); #1 rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    check("pre_rst_count", fifo_count, 1);
    check("pre_rst_data", rx_data, 8'h11);
    fork
      send_byte(8'h81, 1'b1);
      begin
        @(posedge clk);
        repeat (420) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
      end
    join
    @(posedge clk); #1 rst = 1'b0;
    rx_ready = 1'b1;
    exp_q.push_back(8'h7E); send_byte(8'h7E, 1'b1);
    drain("post_rst");
    check("final_ferr", fe_cnt, 1);
    check("final_ovr", ov_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
